// File: rtl/ex_stage_mc_if.sv
// ID/EX-to-EX/MEM bundle for the execute stage: instruction fields and forwarding inputs in,
// registered EX/MEM outputs and the combinational stall back out.
interface ex_stage_mc_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    logic              in_valid;
    logic              flush;
    logic [DATA_W-1:0] pc4;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [REG_W-1:0]  rt_addr;
    logic [REG_W-1:0]  rd_addr;
    logic              alu_src;
    logic              reg_dest;
    logic [1:0]        alu_op;
    logic [5:0]        funct;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] wb_data;
    logic              stall;
    logic              out_valid;
    logic [DATA_W-1:0] out_result;
    logic              out_zero;
    logic [DATA_W-1:0] out_target;
    logic [DATA_W-1:0] out_store;
    logic [REG_W-1:0]  out_rd;

    modport master (
        output in_valid, flush, pc4, rs_data, rt_data, imm, rt_addr, rd_addr,
               alu_src, reg_dest, alu_op, funct, fwd_a, fwd_b, mem_data, wb_data,
        input  stall, out_valid, out_result, out_zero, out_target, out_store, out_rd
    );

    modport slave (
        input  in_valid, flush, pc4, rs_data, rt_data, imm, rt_addr, rd_addr,
               alu_src, reg_dest, alu_op, funct, fwd_a, fwd_b, mem_data, wb_data,
        output stall, out_valid, out_result, out_zero, out_target, out_store, out_rd
    );
endinterface

// File: rtl/ex_stage_mc.sv
// Execute stage with operand forwarding, registered EX/MEM outputs and an iterative shift-add multiply.
// Single-cycle ops land one edge after acceptance; mul holds stall for DATA_W+1 cycles and lands DATA_W+1 edges later.
module ex_stage_mc #(
    parameter int DATA_W    = 32,
    parameter int REG_W     = 5,
    parameter int SHIFT_IMM = 2
) (
    input logic          clock,
    input logic          reset_n,
    ex_stage_mc_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t            stateQ, stateD;
    logic              stallInt;
    logic [DATA_W-1:0] fwdA, fwdB, aluB, aluResult, targetSum;
    logic              isMul;
    logic [DATA_W-1:0] accReg, mcandReg, mplierReg;
    logic [CNT_W-1:0]  stepCnt;
    logic              validQ, zeroQ;
    logic [DATA_W-1:0] resultQ, targetQ, storeQ;
    logic [REG_W-1:0]  rdQ;
    logic [REG_W-1:0]  destReg;

    // Select 2'b11 deliberately falls through to the register-file value.
    always_comb begin
        fwdA = bus.rs_data;
        case (bus.fwd_a)
            2'b01:   fwdA = bus.wb_data;
            2'b10:   fwdA = bus.mem_data;
            default: fwdA = bus.rs_data;
        endcase
        fwdB = bus.rt_data;
        case (bus.fwd_b)
            2'b01:   fwdB = bus.wb_data;
            2'b10:   fwdB = bus.mem_data;
            default: fwdB = bus.rt_data;
        endcase
    end

    assign aluB      = bus.alu_src ? bus.imm : fwdB;
    assign isMul     = (bus.alu_op == 2'b10) && (bus.funct == 6'b011000);
    assign targetSum = bus.pc4 + (bus.imm << SHIFT_IMM);
    assign destReg   = bus.reg_dest ? bus.rd_addr : bus.rt_addr;

    always_comb begin
        aluResult = '0;
        case (bus.alu_op)
            2'b01: aluResult = fwdA - aluB;
            2'b10: begin
                case (bus.funct)
                    6'b100000: aluResult = fwdA + aluB;
                    6'b100010: aluResult = fwdA - aluB;
                    6'b100100: aluResult = fwdA & aluB;
                    6'b100101: aluResult = fwdA | aluB;
                    6'b101010: aluResult = {{(DATA_W-1){1'b0}}, ($signed(fwdA) < $signed(aluB))};
                    default:   aluResult = '0;
                endcase
            end
            default: aluResult = fwdA + aluB;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) stateQ <= IDLE;
        else          stateQ <= stateD;
    end

    always_comb begin
        stateD   = stateQ;
        stallInt = 1'b0;
        if (bus.flush) begin
            stateD = IDLE;
        end else begin
            case (stateQ)
                IDLE: begin
                    if (bus.in_valid && isMul) begin
                        stateD   = MUL;
                        stallInt = 1'b1;
                    end
                end
                MUL: begin
                    stallInt = 1'b1;
                    if (stepCnt == CNT_W'(DATA_W - 1)) stateD = DONE;
                end
                DONE:    stateD = IDLE;
                default: stateD = IDLE;
            endcase
        end
    end

    // DONE drops stall so upstream advances off the mul, but nothing is accepted until IDLE.
    assign bus.stall = stallInt & reset_n;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            validQ    <= 1'b0;
            zeroQ     <= 1'b0;
            resultQ   <= '0;
            targetQ   <= '0;
            storeQ    <= '0;
            rdQ       <= '0;
            accReg    <= '0;
            mcandReg  <= '0;
            mplierReg <= '0;
            stepCnt   <= '0;
        end else if (bus.flush) begin
            validQ  <= 1'b0;
            stepCnt <= '0;
        end else begin
            validQ <= 1'b0;
            case (stateQ)
                IDLE: begin
                    if (bus.in_valid) begin
                        targetQ <= targetSum;
                        storeQ  <= fwdB;
                        rdQ     <= destReg;
                        if (isMul) begin
                            accReg    <= '0;
                            mcandReg  <= fwdA;
                            mplierReg <= aluB;
                            stepCnt   <= '0;
                        end else begin
                            resultQ <= aluResult;
                            zeroQ   <= (aluResult == '0);
                            validQ  <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    if (mplierReg[0]) accReg <= accReg + mcandReg;
                    mcandReg  <= mcandReg << 1;
                    mplierReg <= mplierReg >> 1;
                    stepCnt   <= stepCnt + CNT_W'(1);
                end
                DONE: begin
                    resultQ <= accReg;
                    zeroQ   <= (accReg == '0);
                    validQ  <= 1'b1;
                    stepCnt <= '0;
                end
                default: validQ <= 1'b0;
            endcase
        end
    end

    assign bus.out_valid  = validQ;
    assign bus.out_result = resultQ;
    assign bus.out_zero   = zeroQ;
    assign bus.out_target = targetQ;
    assign bus.out_store  = storeQ;
    assign bus.out_rd     = rdQ;
endmodule

// File: tb/tb_ex_stage_mc.sv
// Scoreboard bench for ex_stage_mc: expected EX/MEM records are queued at issue and popped on out_valid.
module tb_ex_stage_mc;
    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic [31:0] tgt;
        logic [31:0] sto;
        logic [4:0]  rd;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   nChk = 0;
    int   nErr = 0;
    exp_t sb[$];

    ex_stage_mc_if #(.DATA_W(32), .REG_W(5)) bus ();
    ex_stage_mc #(.DATA_W(32), .REG_W(5), .SHIFT_IMM(2)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChk++;
        if (obs !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] reg_v,
                                         input logic [31:0] wb, input logic [31:0] mem);
        if (sel == 2'b01) return wb;
        if (sel == 2'b10) return mem;
        return reg_v;
    endfunction

    // Reference built from the values the bench itself drove.
    function automatic exp_t model();
        exp_t        e;
        logic [31:0] a, fb, b;
        a  = pick(bus.fwd_a, bus.rs_data, bus.wb_data, bus.mem_data);
        fb = pick(bus.fwd_b, bus.rt_data, bus.wb_data, bus.mem_data);
        b  = bus.alu_src ? bus.imm : fb;
        if (bus.alu_op == 2'b10) begin
            case (bus.funct)
                6'b100000: e.res = a + b;
                6'b100010: e.res = a - b;
                6'b100100: e.res = a & b;
                6'b100101: e.res = a | b;
                6'b101010: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                6'b011000: e.res = a * b;
                default:   e.res = 32'd0;
            endcase
        end else if (bus.alu_op == 2'b01) begin
            e.res = a - b;
        end else begin
            e.res = a + b;
        end
        e.zero = (e.res == 32'd0);
        e.tgt  = bus.pc4 + {bus.imm[29:0], 2'b00};
        e.sto  = fb;
        e.rd   = bus.reg_dest ? bus.rd_addr : bus.rt_addr;
        return e;
    endfunction

    task automatic setIns(input logic [1:0] aop, input logic [5:0] fn, input logic [31:0] rs,
                          input logic [31:0] rt, input logic [31:0] im, input logic [31:0] pc,
                          input logic asrc, input logic rdst, input logic [1:0] fa,
                          input logic [1:0] fb, input logic [31:0] mem, input logic [31:0] wb);
        bus.in_valid = 1'b1;
        bus.alu_op   = aop;
        bus.funct    = fn;
        bus.rs_data  = rs;
        bus.rt_data  = rt;
        bus.imm      = im;
        bus.pc4      = pc;
        bus.alu_src  = asrc;
        bus.reg_dest = rdst;
        bus.fwd_a    = fa;
        bus.fwd_b    = fb;
        bus.mem_data = mem;
        bus.wb_data  = wb;
        bus.rt_addr  = 5'd11;
        bus.rd_addr  = 5'd22;
    endtask

    // Holds the instruction until an edge that sees stall low; reports how many cycles stall was high.
    task automatic send(input logic [1:0] aop, input logic [5:0] fn, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] im, input logic [31:0] pc,
                        input logic asrc, input logic rdst, input logic [1:0] fa,
                        input logic [1:0] fb, input logic [31:0] mem, input logic [31:0] wb,
                        output int stallCycles);
        logic st;
        setIns(aop, fn, rs, rt, im, pc, asrc, rdst, fa, fb, mem, wb);
        sb.push_back(model());
        stallCycles = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            st = bus.stall;
            @(posedge clock);
            #1;
            if (!st) break;
            stallCycles++;
            if (i == 99) chk("send_timeout", 1, 0);
        end
        bus.in_valid = 1'b0;
    endtask

    always @(negedge clock) begin
        if (reset_n && bus.out_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", bus.out_result, e.res);
                chk("zero", bus.out_zero, e.zero);
                chk("target", bus.out_target, e.tgt);
                chk("store", bus.out_store, e.sto);
                chk("rd", bus.out_rd, e.rd);
            end
        end
    end

    initial begin
        int sc;
        bus.flush = 1'b0;
        setIns(2'b10, 6'b011000, 32'd3, 32'd4, 32'd0, 32'd0, 1'b0, 1'b1, 2'b00, 2'b00, 32'd0, 32'd0);
        #12;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_result", bus.out_result, 0);
        chk("rst_target", bus.out_target, 0);
        chk("rst_stall", bus.stall, 0);
        bus.in_valid = 1'b0;
        #5 reset_n = 1'b1;
        @(posedge clock);
        #1;

        send(2'b10, 6'b100000, 32'd7, 32'd5, 32'd0, 32'h40, 1'b0, 1'b1, 2'b00, 2'b00, 32'd0, 32'd0, sc);
        chk("add_lat1", bus.out_valid, 1);
        send(2'b01, 6'b000000, 32'd9, 32'd1, 32'd0, 32'h44, 1'b0, 1'b1, 2'b00, 2'b10, 32'd9, 32'd0, sc);
        send(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h48, 1'b0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0, sc);
        send(2'b00, 6'b000000, 32'd1, 32'd2, 32'hFFFF_FFFC, 32'h100, 1'b1, 1'b1, 2'b00, 2'b00, 32'd0, 32'd0, sc);
        send(2'b10, 6'b100100, 32'd0, 32'h0F0F, 32'd0, 32'h50, 1'b0, 1'b1, 2'b01, 2'b11, 32'd0, 32'h0FF0, sc);
        send(2'b10, 6'b100101, 32'hA000, 32'd0, 32'd0, 32'h54, 1'b0, 1'b0, 2'b11, 2'b01, 32'd0, 32'h0005, sc);
        send(2'b10, 6'b111111, 32'd5, 32'd6, 32'd0, 32'h58, 1'b0, 1'b1, 2'b00, 2'b00, 32'd0, 32'd0, sc);
        send(2'b11, 6'b100010, 32'd10, 32'd20, 32'd0, 32'h5C, 1'b0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0, sc);

        send(2'b10, 6'b011000, 32'h0001_0003, 32'h0001_0002, 32'd0, 32'h60, 1'b0, 1'b1, 2'b00, 2'b00, 32'd0, 32'd0, sc);
        chk("mul_stall_cycles", sc, 33);
        send(2'b10, 6'b100000, 32'd1, 32'd1, 32'd0, 32'h64, 1'b0, 1'b1, 2'b00, 2'b00, 32'd0, 32'd0, sc);
        send(2'b10, 6'b011000, 32'd0, 32'd5, 32'hFFFF_FFFD, 32'h68, 1'b1, 1'b0, 2'b10, 2'b00, 32'hFFFF_FFFD, 32'd0, sc);
        chk("mul2_stall_cycles", sc, 33);
        repeat (2) @(posedge clock);
        #1;

        // Flush a mul ten steps in; nothing may come out and stall must release.
        setIns(2'b10, 6'b011000, 32'd6, 32'd7, 32'd0, 32'h70, 1'b0, 1'b1, 2'b00, 2'b00, 32'd0, 32'd0);
        @(posedge clock);
        #1;
        chk("mul_stall_in", bus.stall, 1);
        repeat (10) @(posedge clock);
        #1;
        chk("mul_stall_step10", bus.stall, 1);
        bus.flush = 1'b1;
        #1;
        chk("flush_stall", bus.stall, 0);
        @(posedge clock);
        #1;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_valid", bus.out_valid, 0);
        chk("flush_idle_stall", bus.stall, 0);
        repeat (3) @(posedge clock);
        #1;
        send(2'b10, 6'b100000, 32'd100, 32'd23, 32'd0, 32'h74, 1'b0, 1'b1, 2'b00, 2'b00, 32'd0, 32'd0, sc);
        chk("post_flush_lat1", bus.out_valid, 1);
        chk("post_flush_nostall", sc, 0);
        @(posedge clock);
        #1;

        // Asynchronous reset in the middle of a mul.
        setIns(2'b10, 6'b011000, 32'd6, 32'd7, 32'd0, 32'h80, 1'b0, 1'b1, 2'b00, 2'b00, 32'd0, 32'd0);
        repeat (5) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", bus.out_valid, 0);
        chk("arst_result", bus.out_result, 0);
        chk("arst_target", bus.out_target, 0);
        chk("arst_store", bus.out_store, 0);
        chk("arst_rd", bus.out_rd, 0);
        chk("arst_stall", bus.stall, 0);
        bus.in_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("arst_idle_stall", bus.stall, 0);
        send(2'b10, 6'b100000, 32'd3, 32'd4, 32'd0, 32'h90, 1'b0, 1'b1, 2'b00, 2'b00, 32'd0, 32'd0, sc);
        chk("arst_add", bus.out_result, 7);
        repeat (3) @(posedge clock);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChk, nErr);
        $finish;
    end
endmodule
